// File: rtl/serial_compare_pkg.sv
// Shared types for the serial magnitude compare sequencer: FSM states, the
// one-hot compare result and the counter-width helper.
package serial_compare_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        CoreEq      = 2'd0,
        CoreLess    = 2'd1,
        CoreGreater = 2'd2
    } core_state_e;

    typedef struct packed {
        logic less;
        logic eq;
        logic greater;
    } cmp_result_t;

    localparam cmp_result_t CMP_NONE    = 3'b000;
    localparam cmp_result_t CMP_LESS    = 3'b100;
    localparam cmp_result_t CMP_EQ      = 3'b010;
    localparam cmp_result_t CMP_GREATER = 3'b001;

    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_compare_msb_core.sv
// MSB-first single-bit magnitude comparator: the first differing bit decides
// and the decision is then held until cleared.
module serial_compare_msb_core
    import serial_compare_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic less,
    output logic eq,
    output logic greater
);

    core_state_e state_q, state_d;
    cmp_result_t res;

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = CoreEq;
        end else if (en && (state_q == CoreEq) && (a != b)) begin
            state_d = a ? CoreGreater : CoreLess;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CoreEq;
        end else begin
            state_q <= state_d;
        end
    end

    // While still equal, the bit pair on the inputs already decides the result,
    // so the last bit can be captured in the same cycle it is presented.
    always_comb begin
        res = CMP_EQ;
        case (state_q)
            CoreLess:    res = CMP_LESS;
            CoreGreater: res = CMP_GREATER;
            default: begin
                if (en && (a != b)) begin
                    res = a ? CMP_GREATER : CMP_LESS;
                end
            end
        endcase
    end

    assign less    = res.less;
    assign eq      = res.eq;
    assign greater = res.greater;

endmodule

// File: rtl/serial_compare_sequencer.sv
// Transaction wrapper that streams a parallel operand pair MSB-first through the
// serial comparator and returns a registered one-hot result.
module serial_compare_sequencer
    import serial_compare_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_less,
    output logic             out_eq,
    output logic             out_greater,
    output logic             busy
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    seq_state_e      state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CntW-1:0] cnt_q;
    cmp_result_t     res_q;
    cmp_result_t     core_res;
    logic            in_ready_q, out_valid_q, busy_q;
    logic            accept, core_en;

    assign accept  = (state_q == StIdle) && in_valid;
    assign core_en = (state_q == StShift);

    // Clearing on accept keeps a transaction independent of any stale decision.
    serial_compare_msb_core u_core (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (core_en),
        .a       (a_q[WIDTH-1]),
        .b       (b_q[WIDTH-1]),
        .less    (core_res.less),
        .eq      (core_res.eq),
        .greater (core_res.greater)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            res_q       <= CMP_NONE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_q        <= in_a;
                        b_q        <= in_b;
                        cnt_q      <= CntLast;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StShift;
                    end
                end
                StShift: begin
                    a_q   <= a_q << 1;
                    b_q   <= b_q << 1;
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == '0) begin
                        res_q       <= core_res;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        res_q       <= CMP_NONE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    res_q       <= CMP_NONE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign out_less    = res_q.less;
    assign out_eq      = res_q.eq;
    assign out_greater = res_q.greater;

endmodule

// File: tb/tb_serial_compare_sequencer.sv
// Bench for serial_compare_sequencer: timestamp-based transaction model checked
// every cycle, plus directed literal checks on WIDTH=16 and WIDTH=1 instances.
module tb_serial_compare_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic         out_less, out_eq, out_greater, busy;
    logic [W-1:0] in_a, in_b;

    logic         v1, r1, ov1, or1, l1, e1, g1, bz1;
    logic [0:0]   a1, b1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_compare_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_less    (out_less),
        .out_eq      (out_eq),
        .out_greater (out_greater),
        .busy        (busy)
    );

    serial_compare_sequencer #(.WIDTH(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (v1),
        .in_ready    (r1),
        .in_a        (a1),
        .in_b        (b1),
        .out_valid   (ov1),
        .out_ready   (or1),
        .out_less    (l1),
        .out_eq      (e1),
        .out_greater (g1),
        .busy        (bz1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a < b) return 3'b100;
        if (a == b) return 3'b010;
        return 3'b001;
    endfunction

    // Model: a transaction accepted at edge n0 holds the result back until edge
    // n0+W, then shows it until an edge with out_ready high.
    int         cyc = 0;
    int         m_start = 0;
    bit         m_active = 1'b0;
    logic [2:0] m_res = 3'b000;
    bit         exp_valid;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (in_valid) begin
                m_active = 1'b1;
                m_start  = cyc;
                m_res    = ref_cmp(in_a, in_b);
            end
        end else if ((cyc - 1 - m_start >= W) && out_ready) begin
            m_active = 1'b0;
        end
        #1;
        exp_valid = m_active && (cyc - m_start >= W);
        check("model_in_ready", 32'(in_ready), 32'(!m_active));
        check("model_busy", 32'(busy), 32'(m_active));
        check("model_out_valid", 32'(out_valid), 32'(exp_valid));
        check("model_result", 32'({out_less, out_eq, out_greater}),
              32'(exp_valid ? m_res : 3'b000));
    end

    task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b, input int hold_in,
                       input bit keep, output logic [2:0] res, output int lat,
                       output int bn, output int wt);
        int hold;
        bit seen;
        hold      = hold_in;
        seen      = 1'b0;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        out_ready = (hold == 0);
        wt  = 0;
        lat = -1;
        bn  = 0;
        res = 3'b000;
        while (!in_ready && wt < 50) begin
            wt++;
            @(posedge clk); #2;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #2;
        if (!keep) begin
            in_valid = 1'b0;
            in_a     = ~a;
            in_b     = ~b;
        end
        for (int i = 0; i < 200; i++) begin
            if (seen && !busy) break;
            if (busy) bn++;
            if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    lat  = i;
                    res  = {out_less, out_eq, out_greater};
                end else begin
                    check("result_stable", 32'({out_less, out_eq, out_greater}), 32'(res));
                end
                if (hold > 0) begin
                    check("no_accept_in_done", 32'(in_ready), 32'd0);
                    hold--;
                end else begin
                    out_ready = 1'b1;
                end
            end
            @(posedge clk); #2;
        end
        check("txn_complete", 32'(seen && !busy), 32'd1);
    endtask

    logic [2:0] res;
    int         lat, bn, wt, acc;
    int         mode;

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        v1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0;
        #1 rst = 1'b1;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_result", 32'({out_less, out_eq, out_greater}), 32'd0);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;

        txn(16'h6482, 16'h6262, 0, 1'b0, res, lat, bn, wt);
        check("greater_result", 32'(res), 32'b001);
        check("greater_latency", 32'(lat), 32'd16);
        check("greater_busy_cycles", 32'(bn), 32'd17);

        txn(16'hA5A5, 16'hA5A5, 0, 1'b0, res, lat, bn, wt);
        check("eq_result", 32'(res), 32'b010);
        txn(16'h0001, 16'h8000, 0, 1'b0, res, lat, bn, wt);
        check("msb_less_result", 32'(res), 32'b100);

        // Back-pressure with in_valid held through DONE.
        txn(16'h00FF, 16'h0F00, 5, 1'b1, res, lat, bn, wt);
        check("bp_result", 32'(res), 32'b100);
        check("bp_ready_after_accept", 32'(in_ready), 32'd1);
        txn(16'h00FF, 16'h0F00, 0, 1'b0, res, lat, bn, wt);
        check("bp_next_accept_wait", 32'(wt), 32'd0);
        check("bp_next_result", 32'(res), 32'b100);

        // WIDTH=1 instance.
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; or1 = 1'b1;
        check("w1_ready", 32'(r1), 32'd1);
        @(posedge clk); #2;
        v1 = 1'b0;
        check("w1_busy", 32'(bz1), 32'd1);
        check("w1_not_valid_yet", 32'(ov1), 32'd0);
        @(posedge clk); #2;
        check("w1_valid", 32'(ov1), 32'd1);
        check("w1_greater", 32'({l1, e1, g1}), 32'b001);
        @(posedge clk); #2;
        check("w1_idle", 32'(r1 && !bz1), 32'd1);
        v1 = 1'b1; a1 = 1'b0; b1 = 1'b0;
        @(posedge clk); #2;
        v1 = 1'b0;
        @(posedge clk); #2;
        check("w1_eq", 32'({ov1, l1, e1, g1}), 32'b1010);
        @(posedge clk); #2;

        // Reset while the 8th bit is presented.
        in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0000; out_ready = 1'b1;
        check("rst_pre_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (7) begin @(posedge clk); #2; end
        check("busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #2;
        rst = 1'b0;
        txn(16'h0010, 16'h0010, 0, 1'b0, res, lat, bn, wt);
        check("post_rst_eq", 32'(res), 32'b010);
        check("post_rst_latency", 32'(lat), 32'd16);

        // Random regression; the per-cycle model does the checking.
        acc = 0;
        for (int c = 0; c < 60000 && acc < 1000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            mode      = $urandom_range(0, 3);
            in_a      = W'($urandom);
            if (mode == 0) in_b = in_a;
            else if (mode == 1) in_b = in_a ^ (W'(1) << $urandom_range(0, W - 1));
            else in_b = W'($urandom);
            if (in_valid && in_ready) acc++;
            @(posedge clk); #2;
        end
        check("regress_count", 32'(acc >= 1000), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (W + 4) begin @(posedge clk); #2; end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_compare_sequencer.md
# serial_compare_sequencer

Transaction-level controller around an MSB-first serial magnitude comparator. Accepts a pair of WIDTH-bit operands through a valid/ready handshake, streams them one bit per cycle (MSB first) into a serial comparator core, and returns a registered one-hot result through a second valid/ready handshake. It lets parallel-bus blocks in the sequential-basics datapath reuse the single-bit comparator without hand-sequencing bits.

## Interface
- WIDTH, 16, operand width in bits; legal range 1..64
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer can accept operands (high only in IDLE)
- in_a  in  WIDTH  operand A, unsigned
- in_b  in  WIDTH  operand B, unsigned
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_less  out  1  A < B
- out_eq  out  1  A == B
- out_greater  out  1  A > B
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&in_ready: load in_a/in_b into shift registers, load bit counter with WIDTH-1, pulse core clr → SHIFT.
- SHIFT: present shift-register MSBs to core with en=1; shift left by one; decrement counter. When counter==0 on an edge: capture core's combinational less/eq/greater into result register → DONE.
- DONE: out_valid=1, result held stable. On out_valid&out_ready → IDLE. No same-cycle accept of new operands.
- Core semantics: first differing bit decides; later bits never change the decision; all bits equal → eq.
- Result outputs exactly one-hot while out_valid=1; all zero while out_valid=0.
- in_valid ignored outside IDLE; in_a/in_b need not be held after accept.
- Unsigned compare only; no early termination on first difference (fixed latency).
- Counter width: $clog2(WIDTH) bits, minimum 1.

## Timing
- Reset values (async, immediate on rst rise): state IDLE, in_ready=1, out_valid=0, out_less/eq/greater=0, busy=0, core state cleared. Handshakes are not sampled while rst=1.
- Accept edge E0. During the cycle after edge E(k-1), bit WIDTH-k is presented, for k=1..WIDTH.
- At edge E_WIDTH, result registered; out_valid=1 in the cycle after E_WIDTH.
- busy high from the cycle after E0 through the result-accept edge, inclusive.
- Result-accept edge Er → in_ready=1 in the cycle after Er; next accept is at earliest Er+1.
- Minimum period per transaction: WIDTH+2 cycles.
- rst mid-SHIFT or mid-DONE: transaction dropped, no out_valid; next transaction unaffected by stale core state.

## Structure
- Package serial_compare_pkg: state enum (IDLE, SHIFT, DONE), one-hot result typedef {less, eq, greater}, and constants CMP_LESS/CMP_EQ/CMP_GREATER.
- Sub-module serial_compare_msb_core: clk, rst (async), clr (sync), en, a, b → less, eq, greater. Three-state FSM (equal / a_less_b / a_greater_b); leaves equal on first differing bit when en=1, then holds. Outputs are combinational from state and current bits. Sequencer holds the FSM, shift registers, counter and result register.

## Test plan
- WIDTH=16, a=16'h6482, b=16'h6262, out_ready=1 → out_greater=1 (less/eq=0) exactly in the cycle after E16; busy high 17 cycles.
- a=b=16'hA5A5 → out_eq=1 only; next pair a=16'h0001, b=16'h8000 → out_less=1 (MSB decides; bit 0 does not flip it).
- Back-pressure: out_ready low 5 cycles in DONE with in_valid held high → result stable, in_ready=0, no accept; after out_ready=1, accept occurs one cycle after the result-accept edge.
- rst pulsed while the 8th bit is presented (a=16'hFFFF, b=16'h0000) → out_valid/busy drop to 0 without waiting for clk; next pair a=16'h0010, b=16'h0010 → out_eq=1.
- WIDTH=1: a=1, b=0 → out_greater in the cycle after E1; a=0, b=0 → out_eq.
- Random regression (≥1000 pairs, random in_valid/out_ready gaps) against a reference compare of in_a/in_b; check one-hot outputs and the fixed latency.
